// File: rtl/instr_prefetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// panzer16_pkg
// Shared types and constants for the panzer16 instruction front end.
//   DATA_W        instruction word width
//   ADDR_W        instruction memory word-address width
//   RESET_VECTOR  first fetch address after reset
//   fetch_state_e prefetch sequencer states
// -----------------------------------------------------------------------------
package panzer16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_prefetch_unit_checker.sv
// -----------------------------------------------------------------------------
// instr_prefetch_unit_checker
// Simulation-only invariants of the prefetch unit.
// Ports:
//   Clk, Rst       clock, asynchronous active-low reset
//   Fifo_Enqueue   enqueue strobe towards the FIFO
//   Fifo_Full      FIFO full flag
//   Credits        current FIFO credit count
//   Outstanding    current reads in flight
// -----------------------------------------------------------------------------
module instr_prefetch_unit_checker #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CRED_W          = 3,
  parameter int OUTS_W          = 2
) (
  input logic              Clk,
  input logic              Rst,
  input logic              Fifo_Enqueue,
  input logic              Fifo_Full,
  input logic [CRED_W-1:0] Credits,
  input logic [OUTS_W-1:0] Outstanding
);

  // Credit accounting must make a push into a full FIFO impossible
  a_no_enq_when_full: assert property (@(posedge Clk) disable iff (!Rst)
    !(Fifo_Enqueue && Fifo_Full))
    else $error("prefetch: enqueue while FIFO full");

  // Credits never exceed the FIFO depth
  a_credit_range: assert property (@(posedge Clk) disable iff (!Rst)
    Credits <= CRED_W'(DEPTH))
    else $error("prefetch: credit count above depth");

  // In-flight reads never exceed the configured cap
  a_outs_range: assert property (@(posedge Clk) disable iff (!Rst)
    Outstanding <= OUTS_W'(MAX_OUTSTANDING))
    else $error("prefetch: too many reads in flight");

endmodule

// File: rtl/instr_prefetch_unit_fetch_credit_counter.sv
// -----------------------------------------------------------------------------
// fetch_credit_counter
// Up/down counter with synchronous load, used for FIFO credits and for reads
// in flight. Load has priority; simultaneous Inc and Dec leave it unchanged.
// Ports:
//   Clk, Rst      clock, asynchronous active-low reset
//   Load          replace count with Load_Value
//   Load_Value    value loaded when Load=1
//   Inc, Dec      +1 / -1 requests
//   Count         registered count
//   Count_Next    value Count takes at the next edge (for registered lookahead)
// -----------------------------------------------------------------------------
module fetch_credit_counter #(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Value,
  input  logic             Inc,
  input  logic             Dec,
  output logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] Count_Next
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;

  // Next-count selection: load first, then net increment/decrement
  always_comb begin
    count_next_s = count_r;
    if (Load) begin
      count_next_s = Load_Value;
    end else if (Inc && !Dec) begin
      count_next_s = count_r + ONE;
    end else if (Dec && !Inc) begin
      count_next_s = count_r - ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_r <= RESET_VAL;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign Count      = count_r;
  assign Count_Next = count_next_s;

endmodule

// File: rtl/instr_prefetch_unit.sv
// -----------------------------------------------------------------------------
// instr_prefetch_unit
// Feeds the 4-slot instruction FIFO: issues sequential word reads, enqueues the
// returned words in order and keeps a credit count so the FIFO never overfills.
// A redirect flushes the FIFO, discards reads still in flight and refetches.
// Ports:
//   Clk             clock (rising edge)
//   Rst             asynchronous active-low reset
//   Fetch_En        allow new reads
//   Redirect        1-cycle branch-taken pulse
//   Redirect_Addr   restart address
//   Mem_Req/Addr    registered read request / word address
//   Mem_Gnt         memory accepts the pending request
//   Mem_Rvalid/Rdata in-order read return
//   Fifo_DataIn     registered word to FIFO
//   Fifo_Enqueue    registered enqueue strobe
//   Fifo_Dequeue    consumer dequeue (returns a credit)
//   Fifo_Full       FIFO full (monitored only)
//   Fifo_Flush      registered 1-cycle flush pulse
// -----------------------------------------------------------------------------
module instr_prefetch_unit
  import panzer16_pkg::*;
#(
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR    = panzer16_pkg::RESET_VECTOR
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Fetch_En,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_Addr,
  output logic              Mem_Req,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Gnt,
  input  logic              Mem_Rvalid,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic [DATA_W-1:0] Fifo_DataIn,
  output logic              Fifo_Enqueue,
  input  logic              Fifo_Dequeue,
  input  logic              Fifo_Full,
  output logic              Fifo_Flush
);

  localparam int CRED_W = $clog2(DEPTH + 1);
  localparam int OUTS_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [OUTS_W-1:0] OUTS_ONE = {{(OUTS_W-1){1'b0}}, 1'b1};
  localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(MAX_OUTSTANDING);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DEPTH);

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_req_r;
  logic              req_next_s;
  logic              issue_s;
  logic              keep_s;
  logic              fifo_enq_r;
  logic              fifo_flush_r;
  logic [DATA_W-1:0] fifo_data_r;
  logic [CRED_W-1:0] credits_s;
  logic [CRED_W-1:0] credits_next_s;
  logic [OUTS_W-1:0] outs_s;
  logic [OUTS_W-1:0] outs_next_s;
  logic [OUTS_W-1:0] discard_r;
  logic [OUTS_W-1:0] discard_next_s;

  assign issue_s = mem_req_r & Mem_Gnt;
  // A return is kept only when no redirect drops it and nothing is owed to discard
  assign keep_s  = Mem_Rvalid & ~Redirect & (discard_r == {OUTS_W{1'b0}});

  // FIFO slots still free, counting words already requested; redirect refills
  fetch_credit_counter #(
    .WIDTH     (CRED_W),
    .RESET_VAL (CRED_MAX)
  ) u_credits (
    .Clk        (Clk),
    .Rst        (Rst),
    .Load       (Redirect),
    .Load_Value (CRED_MAX),
    .Inc        (Fifo_Dequeue),
    .Dec        (issue_s),
    .Count      (credits_s),
    .Count_Next (credits_next_s)
  );

  // Reads granted but not yet returned, including ones that will be discarded
  fetch_credit_counter #(
    .WIDTH     (OUTS_W),
    .RESET_VAL ({OUTS_W{1'b0}})
  ) u_outstanding (
    .Clk        (Clk),
    .Rst        (Rst),
    .Load       (1'b0),
    .Load_Value ({OUTS_W{1'b0}}),
    .Inc        (issue_s),
    .Dec        (Mem_Rvalid),
    .Count      (outs_s),
    .Count_Next (outs_next_s)
  );

  // Sequencer: stay in RUN while an ungranted request is held, even if fetching stops
  always_comb begin
    state_next_s = state_r;
    if (Fetch_En) begin
      state_next_s = ST_RUN;
    end else if (mem_req_r && !Mem_Gnt && !Redirect) begin
      state_next_s = ST_RUN;
    end else begin
      state_next_s = ST_IDLE;
    end
  end

  // Next pc, discard count and request, evaluated on post-edge counter values
  always_comb begin
    pc_next_s      = pc_r;
    discard_next_s = discard_r;
    req_next_s     = 1'b0;
    if (Redirect) begin
      pc_next_s      = Redirect_Addr;
      // everything still in flight after this edge belongs to the old path
      discard_next_s = outs_next_s;
      req_next_s     = 1'b0;
    end else begin
      if (issue_s) begin
        pc_next_s = pc_r + PC_ONE;
      end else begin
        pc_next_s = pc_r;
      end
      if (Mem_Rvalid && (discard_r != {OUTS_W{1'b0}})) begin
        discard_next_s = discard_r - OUTS_ONE;
      end else begin
        discard_next_s = discard_r;
      end
      req_next_s = (state_next_s == ST_RUN) &&
                   (credits_next_s != {CRED_W{1'b0}}) &&
                   (outs_next_s < OUTS_MAX);
    end
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_VECTOR;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= RESET_VECTOR;
      discard_r    <= {OUTS_W{1'b0}};
      fifo_enq_r   <= 1'b0;
      fifo_data_r  <= {DATA_W{1'b0}};
      fifo_flush_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pc_r         <= pc_next_s;
      mem_req_r    <= req_next_s;
      // address tracks pc, so it stays stable while a request waits for grant
      mem_addr_r   <= pc_next_s;
      discard_r    <= discard_next_s;
      fifo_enq_r   <= keep_s;
      fifo_flush_r <= Redirect;
      if (keep_s) begin
        fifo_data_r <= Mem_Rdata;
      end else begin
        fifo_data_r <= fifo_data_r;
      end
    end
  end

  assign Mem_Req      = mem_req_r;
  assign Mem_Addr     = mem_addr_r;
  assign Fifo_Enqueue = fifo_enq_r;
  assign Fifo_DataIn  = fifo_data_r;
  assign Fifo_Flush   = fifo_flush_r;

  instr_prefetch_unit_checker #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CRED_W          (CRED_W),
    .OUTS_W          (OUTS_W)
  ) u_checker (
    .Clk          (Clk),
    .Rst          (Rst),
    .Fifo_Enqueue (fifo_enq_r),
    .Fifo_Full    (Fifo_Full),
    .Credits      (credits_s),
    .Outstanding  (outs_s)
  );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_unit
// Directed bench: a fixed-latency memory model and a FIFO occupancy model drive
// the prefetch unit; issued addresses and enqueued words are logged and checked
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_unit;

  logic        Clk;
  logic        Rst;
  logic        Fetch_En;
  logic        Redirect;
  logic [15:0] Redirect_Addr;
  logic        Mem_Req;
  logic [15:0] Mem_Addr;
  logic        Mem_Gnt;
  logic        Mem_Rvalid;
  logic [15:0] Mem_Rdata;
  logic [15:0] Fifo_DataIn;
  logic        Fifo_Enqueue;
  logic        Fifo_Dequeue;
  logic        Fifo_Full;
  logic        Fifo_Flush;

  int checks   = 0;
  int failures = 0;

  int          cyc          = 0;
  logic [15:0] iss_addr [0:255];
  int          iss_cyc  [0:255];
  int          iss_n        = 0;
  int          ret_ptr      = 0;
  logic [15:0] enq_log  [0:255];
  int          enq_n        = 0;
  int          deq_n        = 0;
  int          flush_n      = 0;
  int          occ          = 0;
  int          max_inflight = 0;
  int          lat          = 1;
  bit          deq_en       = 1'b0;
  int          base_i;
  int          base_e;

  instr_prefetch_unit dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Fetch_En      (Fetch_En),
    .Redirect      (Redirect),
    .Redirect_Addr (Redirect_Addr),
    .Mem_Req       (Mem_Req),
    .Mem_Addr      (Mem_Addr),
    .Mem_Gnt       (Mem_Gnt),
    .Mem_Rvalid    (Mem_Rvalid),
    .Mem_Rdata     (Mem_Rdata),
    .Fifo_DataIn   (Fifo_DataIn),
    .Fifo_Enqueue  (Fifo_Enqueue),
    .Fifo_Dequeue  (Fifo_Dequeue),
    .Fifo_Full     (Fifo_Full),
    .Fifo_Flush    (Fifo_Flush)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign Fifo_Full = (occ == 4);

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clk);
  endtask

  // Edge monitor: log issues, returns, enqueues, dequeues, flushes; FIFO occupancy
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (!Rst) begin
      ret_ptr <= iss_n;
      occ     <= 0;
    end else begin
      if (Mem_Req && Mem_Gnt) begin
        iss_addr[iss_n] <= Mem_Addr;
        iss_cyc[iss_n]  <= cyc;
        iss_n           <= iss_n + 1;
      end
      if (Mem_Rvalid) ret_ptr <= ret_ptr + 1;
      if (Fifo_Enqueue) begin
        enq_log[enq_n] <= Fifo_DataIn;
        enq_n          <= enq_n + 1;
      end
      if (Fifo_Dequeue) deq_n <= deq_n + 1;
      if (Fifo_Flush) begin
        flush_n <= flush_n + 1;
        occ     <= 0;
      end else begin
        occ <= occ + (Fifo_Enqueue ? 1 : 0) - (Fifo_Dequeue ? 1 : 0);
      end
    end
  end

  // Memory returns (fixed latency, in order) and consumer dequeues every 2nd cycle
  always @(negedge Clk) begin
    #1;
    if (Rst && (ret_ptr < iss_n) && (cyc >= iss_cyc[ret_ptr] + lat)) begin
      Mem_Rvalid = 1'b1;
      Mem_Rdata  = mem_data(iss_addr[ret_ptr]);
    end else begin
      Mem_Rvalid = 1'b0;
      Mem_Rdata  = 16'h0000;
    end
    if (deq_en && (occ != 0)) Fifo_Dequeue = ~Fifo_Dequeue;
    else                      Fifo_Dequeue = 1'b0;
    if (iss_n - ret_ptr > max_inflight) max_inflight = iss_n - ret_ptr;
  end

  initial begin
    Rst           = 1'b0;
    Fetch_En      = 1'b0;
    Redirect      = 1'b0;
    Redirect_Addr = 16'h0000;
    Mem_Gnt       = 1'b0;
    Mem_Rvalid    = 1'b0;
    Mem_Rdata     = 16'h0000;
    Fifo_Dequeue  = 1'b0;

    // Reset state
    tick; tick;
    check("rst_mem_req",  {31'd0, Mem_Req},      32'd0);
    check("rst_mem_addr", {16'd0, Mem_Addr},     32'h0000);
    check("rst_enq",      {31'd0, Fifo_Enqueue}, 32'd0);
    check("rst_datain",   {16'd0, Fifo_DataIn},  32'h0000);
    check("rst_flush",    {31'd0, Fifo_Flush},   32'd0);
    Rst = 1'b1;
    tick;
    check("idle_no_req",  {31'd0, Mem_Req},      32'd0);

    // 1: fill the FIFO from reset vector with 1-cycle returns
    Fetch_En = 1'b1;
    Mem_Gnt  = 1'b1;
    repeat (10) tick;
    check("t1_issues",  iss_n,                   32'd4);
    check("t1_addr0",   {16'd0, iss_addr[0]},    32'h0000);
    check("t1_addr1",   {16'd0, iss_addr[1]},    32'h0001);
    check("t1_addr2",   {16'd0, iss_addr[2]},    32'h0002);
    check("t1_addr3",   {16'd0, iss_addr[3]},    32'h0003);
    check("t1_enqs",    enq_n,                   32'd4);
    check("t1_word0",   {16'd0, enq_log[0]},     {16'd0, mem_data(16'h0000)});
    check("t1_word3",   {16'd0, enq_log[3]},     {16'd0, mem_data(16'h0003)});
    check("t1_req_off", {31'd0, Mem_Req},        32'd0);
    check("t1_pc",      {16'd0, Mem_Addr},       32'h0004);

    // 2: dequeue every 2nd cycle, one issue per returned credit
    deq_en = 1'b1;
    repeat (16) tick;
    deq_en = 1'b0;
    repeat (8) tick;
    check("t2_deqs",    deq_n,                   32'd8);
    check("t2_issues",  iss_n,                   32'd12);
    check("t2_enqs",    enq_n,                   32'd12);
    check("t2_addr11",  {16'd0, iss_addr[11]},   32'h000B);
    check("t2_word11",  {16'd0, enq_log[11]},    {16'd0, mem_data(16'h000B)});
    check("t2_req_off", {31'd0, Mem_Req},        32'd0);

    // 3: request held without grant, then 3-cycle latency caps in-flight at 2
    Mem_Gnt = 1'b0;
    deq_en  = 1'b1;
    repeat (8) tick;
    deq_en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_req",  {31'd0, Mem_Req},  32'd1);
      check("t3_hold_addr", {16'd0, Mem_Addr}, 32'h000C);
      tick;
    end
    check("t3_no_issue", iss_n, 32'd12);
    max_inflight = 0;
    lat     = 3;
    Mem_Gnt = 1'b1;
    repeat (20) tick;
    check("t3_issues",   iss_n,                 32'd16);
    check("t3_addr15",   {16'd0, iss_addr[15]}, 32'h000F);
    check("t3_enqs",     enq_n,                 32'd16);
    check("t3_word15",   {16'd0, enq_log[15]},  {16'd0, mem_data(16'h000F)});
    check("t3_inflight", max_inflight,          32'd2);

    // 4: redirect with two reads in flight
    Mem_Gnt = 1'b0;
    deq_en  = 1'b1;
    repeat (8) tick;
    deq_en  = 1'b0;
    Mem_Gnt = 1'b1;
    tick; tick;
    Redirect      = 1'b1;
    Redirect_Addr = 16'h0100;
    tick;
    Redirect = 1'b0;
    check("t4_flush_on",  {31'd0, Fifo_Flush},   32'd1);
    check("t4_req_drop",  {31'd0, Mem_Req},      32'd0);
    check("t4_enq_off",   {31'd0, Fifo_Enqueue}, 32'd0);
    tick;
    check("t4_flush_off", {31'd0, Fifo_Flush},   32'd0);
    check("t4_new_req",   {31'd0, Mem_Req},      32'd1);
    check("t4_new_addr",  {16'd0, Mem_Addr},     32'h0100);
    repeat (16) tick;
    check("t4_issues",    iss_n,                 32'd22);
    check("t4_addr17",    {16'd0, iss_addr[17]}, 32'h0011);
    check("t4_addr18",    {16'd0, iss_addr[18]}, 32'h0100);
    check("t4_enqs",      enq_n,                 32'd20);
    check("t4_word16",    {16'd0, enq_log[16]},  {16'd0, mem_data(16'h0100)});
    check("t4_flushes",   flush_n,               32'd1);

    // 5: address wrap from FFFE
    Mem_Gnt = 1'b0;
    lat     = 1;
    deq_en  = 1'b1;
    repeat (8) tick;
    deq_en  = 1'b0;
    check("t5_pending_addr", {16'd0, Mem_Addr}, 32'h0104);
    Redirect      = 1'b1;
    Redirect_Addr = 16'hFFFE;
    tick;
    Redirect = 1'b0;
    check("t5_withdrawn", {31'd0, Mem_Req},      32'd0);
    Mem_Gnt = 1'b1;
    repeat (10) tick;
    check("t5_issues",    iss_n,                 32'd26);
    check("t5_addr_fffe", {16'd0, iss_addr[22]}, 32'hFFFE);
    check("t5_addr_ffff", {16'd0, iss_addr[23]}, 32'hFFFF);
    check("t5_addr_0000", {16'd0, iss_addr[24]}, 32'h0000);
    check("t5_addr_0001", {16'd0, iss_addr[25]}, 32'h0001);
    check("t5_pc",        {16'd0, Mem_Addr},     32'h0002);
    check("t5_enqs",      enq_n,                 32'd24);
    check("t5_word_fffe", {16'd0, enq_log[20]},  {16'd0, mem_data(16'hFFFE)});
    check("t5_flushes",   flush_n,               32'd2);

    // 6: reset in the middle of fetching with returns pending
    lat    = 3;
    deq_en = 1'b1;
    repeat (7) tick;
    Rst    = 1'b0;
    deq_en = 1'b0;
    #1;
    check("t6_rst_req",    {31'd0, Mem_Req},      32'd0);
    check("t6_rst_addr",   {16'd0, Mem_Addr},     32'h0000);
    check("t6_rst_enq",    {31'd0, Fifo_Enqueue}, 32'd0);
    check("t6_rst_datain", {16'd0, Fifo_DataIn},  32'h0000);
    check("t6_rst_flush",  {31'd0, Fifo_Flush},   32'd0);
    repeat (2) tick;
    lat    = 1;
    base_i = iss_n;
    base_e = enq_n;
    Rst    = 1'b1;
    repeat (12) tick;
    check("t6_issues", iss_n - base_i,             32'd4);
    check("t6_addr0",  {16'd0, iss_addr[base_i]},  32'h0000);
    check("t6_addr3",  {16'd0, iss_addr[base_i+3]}, 32'h0003);
    check("t6_enqs",   enq_n - base_e,             32'd4);
    check("t6_word0",  {16'd0, enq_log[base_e]},   {16'd0, mem_data(16'h0000)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
